instr_loader: RTL and testbench

- Boot-time program loader, directly upstream of the single-cycle processor's instruction memory.
- Accepts a little-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the processor core in reset until the full program has been written, then releases it.

---
 rtl/instr_loader.sv | 138 +++++++++++++
 tb/tb_instr_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: boot loader that assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until the program is in place.
module instr_loader #(
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                  CLK,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  im_we,
   output logic [ADDR_WIDTH-1:0] im_addr,
   output logic [31:0]           im_wdata,
   output logic                  cpu_reset,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [15:0]           word_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] W_ONE = 1;
   localparam logic [TW-1:0] T_ONE = 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR} state_t;

   state_t              state;
   logic [7:0]          len_lo;
   logic [23:0]         shreg;
   logic [1:0]          bidx;
   logic [ADDR_WIDTH:0] widx;
   logic [TW-1:0]       tcnt;
   logic                accept;
   logic [15:0]         n;
   logic [ADDR_WIDTH:0] widx_nxt;

   assign accept   = rx_valid && rx_ready;
   assign n        = {rx_data, len_lo};
   assign widx_nxt = widx + W_ONE;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rx_ready   <= 1'b0;
         im_we      <= 1'b0;
         im_addr    <= '0;
         im_wdata   <= '0;
         word_count <= '0;
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         len_lo     <= '0;
         shreg      <= '0;
         bidx       <= '0;
         widx       <= '0;
         tcnt       <= '0;
      end else begin
         im_we <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state     <= LEN_LO;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  cpu_reset <= 1'b1;
                  rx_ready  <= 1'b1;
                  widx      <= '0;
                  bidx      <= '0;
                  tcnt      <= '0;
               end
            end
            LEN_LO, LEN_HI, DATA: begin
               if (accept) begin
                  tcnt <= '0;
                  if (state == LEN_LO) begin
                     len_lo <= rx_data;
                     state  <= LEN_HI;
                  end else if (state == LEN_HI) begin
                     word_count <= n;
                     if (n == 16'd0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                        rx_ready  <= 1'b0;
                     end else if ({1'b0, n} > CAP) begin
                        state    <= ERROR;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        rx_ready <= 1'b0;
                     end else begin
                        state <= DATA;
                     end
                  end else begin
                     // earlier bytes shift down so byte 0 ends up in the low lane
                     shreg <= {rx_data, shreg[23:8]};
                     bidx  <= bidx + 2'd1;
                     if (bidx == 2'd3) begin
                        state    <= WRITE;
                        rx_ready <= 1'b0;
                        im_we    <= 1'b1;
                        im_addr  <= widx[ADDR_WIDTH-1:0];
                        im_wdata <= {rx_data, shreg};
                     end
                  end
               end else if (tcnt == T_LAST) begin
                  state    <= ERROR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  rx_ready <= 1'b0;
                  tcnt     <= '0;
               end else begin
                  tcnt <= tcnt + T_ONE;
               end
            end
            WRITE: begin
               widx <= widx_nxt;
               bidx <= '0;
               if (16'(widx_nxt) == word_count) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  state    <= DATA;
                  rx_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed checks of header parsing, word assembly, timeout and reset behaviour.
module tb_instr_loader;
   localparam int AW = 8;
   localparam int TO = 1000;

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    rx_data = 8'd0;
   logic          rx_valid = 1'b0;
   logic          rx_ready, im_we, cpu_reset, busy, done, error;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic [15:0]   word_count;

   int checks = 0;
   int failures = 0;
   int writes = 0;
   int overlap = 0;
   int w0;
   logic [31:0] mem [0:255];

   instr_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error), .word_count(word_count)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (im_we) begin
         mem[im_addr] <= im_wdata;
         writes <= writes + 1;
         if (rx_ready) overlap <= overlap + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      repeat (gap) @(negedge CLK);
      rx_data  = b;
      rx_valid = 1'b1;
      for (int i = 0; i < 50 && !rx_ready; i++) @(negedge CLK);
      if (!rx_ready) chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
      @(negedge CLK);
      rx_valid = 1'b0;
   endtask

   task automatic send_all(input logic [7:0] q[$], input int maxgap);
      foreach (q[i]) send(q[i], maxgap == 0 ? 0 : int'($urandom_range(0, maxgap)));
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 200 && !done; i++) @(negedge CLK);
      chk(tag, {31'd0, done}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge CLK);
      chk("rst_rx_ready", {31'd0, rx_ready}, 0);
      chk("rst_im_we", {31'd0, im_we}, 0);
      chk("rst_im_addr", {24'd0, im_addr}, 0);
      chk("rst_im_wdata", im_wdata, 0);
      chk("rst_word_count", {16'd0, word_count}, 0);
      chk("rst_cpu_reset", {31'd0, cpu_reset}, 1);
      chk("rst_flags", {29'd0, busy, done, error}, 0);
      reset = 1'b0;
      @(negedge CLK);

      // normal two-word load with cycle-exact write checks
      pulse_start();
      chk("start_busy", {31'd0, busy}, 1);
      chk("start_rx_ready", {31'd0, rx_ready}, 1);
      send_all('{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00}, 0);
      chk("w0_we", {31'd0, im_we}, 1);
      chk("w0_addr", {24'd0, im_addr}, 0);
      chk("w0_data", im_wdata, 32'h00A00513);
      chk("w0_rx_ready", {31'd0, rx_ready}, 0);
      send_all('{8'h93, 8'h05, 8'hB0, 8'h00}, 0);
      chk("w1_we", {31'd0, im_we}, 1);
      chk("w1_addr", {24'd0, im_addr}, 1);
      chk("w1_data", im_wdata, 32'h00B00593);
      chk("w1_not_done", {30'd0, done, cpu_reset}, 32'd1);
      @(negedge CLK);
      chk("n_done", {31'd0, done}, 1);
      chk("n_cpu_reset", {31'd0, cpu_reset}, 0);
      chk("n_busy_we", {30'd0, busy, im_we}, 0);
      chk("n_word_count", {16'd0, word_count}, 2);
      chk("n_writes", writes, 2);

      // empty program
      w0 = writes;
      pulse_start();
      chk("e_cpu_reset", {31'd0, cpu_reset}, 1);
      chk("e_done_clr", {31'd0, done}, 0);
      send_all('{8'h00, 8'h00}, 0);
      chk("e_done", {31'd0, done}, 1);
      chk("e_cpu_reset_rel", {31'd0, cpu_reset}, 0);
      chk("e_word_count", {16'd0, word_count}, 0);
      @(negedge CLK);
      chk("e_writes", writes, w0);

      // oversize header N=257
      pulse_start();
      send_all('{8'h01, 8'h01}, 0);
      chk("o_error", {31'd0, error}, 1);
      chk("o_cpu_reset", {31'd0, cpu_reset}, 1);
      chk("o_word_count", {16'd0, word_count}, 257);
      chk("o_busy_ready", {30'd0, busy, rx_ready}, 0);
      @(negedge CLK);
      chk("o_writes", writes, w0);

      // gaps, backpressure and an ignored start mid-load
      pulse_start();
      chk("b_error_clr", {31'd0, error}, 0);
      send_all('{8'h03, 8'h00, 8'h44, 8'h33}, 4);
      pulse_start();
      chk("b_start_ignored", {31'd0, busy}, 1);
      send_all('{8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00}, 4);
      wait_done("b_done");
      @(negedge CLK);
      chk("b_mem0", mem[0], 32'h11223344);
      chk("b_mem1", mem[1], 32'hDEADBEEF);
      chk("b_mem2", mem[2], 32'h00000013);
      chk("b_writes", writes, w0 + 3);
      chk("b_ready_in_write", overlap, 0);

      // timeout after two body bytes of the second word
      w0 = writes;
      pulse_start();
      send_all('{8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02}, 0);
      repeat (TO - 1) @(negedge CLK);
      chk("t_not_yet", {30'd0, error, busy}, 1);
      @(negedge CLK);
      chk("t_error", {31'd0, error}, 1);
      chk("t_cpu_reset", {31'd0, cpu_reset}, 1);
      chk("t_rx_ready", {31'd0, rx_ready}, 0);
      chk("t_writes", writes, w0 + 1);
      chk("t_mem0", mem[0], 32'hDDCCBBAA);
      chk("t_mem1_kept", mem[1], 32'hDEADBEEF);
      pulse_start();
      send_all('{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00}, 2);
      wait_done("t_reload_done");
      @(negedge CLK);
      chk("t_reload_mem0", mem[0], 32'h00A00513);
      chk("t_reload_mem1", mem[1], 32'h00B00593);
      chk("t_reload_cpu_reset", {31'd0, cpu_reset}, 0);

      // asynchronous reset in the middle of a word
      pulse_start();
      send_all('{8'h02, 8'h00, 8'h13, 8'h05}, 0);
      #2 reset = 1'b1;
      #1;
      chk("r_cpu_reset", {31'd0, cpu_reset}, 1);
      chk("r_flags", {29'd0, busy, done, error}, 0);
      chk("r_rx_ready", {31'd0, rx_ready}, 0);
      chk("r_word_count", {16'd0, word_count}, 0);
      @(negedge CLK);
      reset = 1'b0;
      @(negedge CLK);
      pulse_start();
      send_all('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 0);
      wait_done("r_reload_done");
      @(negedge CLK);
      chk("r_reload_mem0", mem[0], 32'h12345678);
      chk("r_reload_count", {16'd0, word_count}, 1);
      chk("r_reload_cpu_reset", {31'd0, cpu_reset}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
